// File: rtl/fpu_seq_core.sv
// fpu_seq_core: multi-cycle floating-point add/sub/mul/div with start/done handshake.
// Subnormals flush to zero, rounding is truncation, and results carry per-operation exception flags.
module fpu_seq_core #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned BIAS  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;  // packed word
  localparam int unsigned N  = MAN_W + 1;          // significand with hidden bit
  localparam int unsigned SW = MAN_W + 2;          // working mantissa {carry, hidden, frac}
  localparam int unsigned DW = MAN_W + 3;          // divider remainder
  localparam int unsigned XW = EXP_W + 2;          // signed working exponent
  localparam int unsigned CW = $clog2(MAN_W + 2);  // iteration counter

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_UNPACK = 4'd1;
  localparam logic [3:0] S_ALIGN  = 4'd2;
  localparam logic [3:0] S_ADDSUB = 4'd3;
  localparam logic [3:0] S_MUL    = 4'd4;
  localparam logic [3:0] S_DIV    = 4'd5;
  localparam logic [3:0] S_NORM   = 4'd6;
  localparam logic [3:0] S_PACK   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic [3:0]              r_state;
  logic [3:0]              w_next;
  logic [1:0]              r_op;
  logic [W-1:0]            r_a;
  logic [W-1:0]            r_b;
  logic                    r_sa;
  logic                    r_sb;
  logic [EXP_W-1:0]        r_ea;
  logic [EXP_W-1:0]        r_eb;
  logic [SW-1:0]           r_ma;
  logic [SW-1:0]           r_mb;
  logic                    r_sign;
  logic signed [XW-1:0]    r_exp;
  logic [SW-1:0]           r_m;
  logic                    r_special;
  logic [W-1:0]            r_pre;
  logic [3:0]              r_flg;
  logic [N-1:0]            r_mcand;
  logic [2*N-1:0]          r_prod;
  logic [DW-1:0]           r_rem;
  logic [DW-1:0]           r_dvs;
  logic [CW-1:0]           r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic [W-1:0]            r_result;
  logic [3:0]              r_flags;

  // True when the working mantissa has the hidden bit set and no carry.
  function automatic logic is_norm(input logic [SW-1:0] m);
    return !m[SW-1] && m[SW-2];
  endfunction

  // Operand decode of the latched inputs.
  logic                 w_sa;
  logic                 w_sb_raw;
  logic                 w_sb_eff;
  logic                 w_sxor;
  logic [EXP_W-1:0]     w_ea_f;
  logic [EXP_W-1:0]     w_eb_f;
  logic [MAN_W-1:0]     w_fa;
  logic [MAN_W-1:0]     w_fb;
  logic                 w_za;
  logic                 w_zb;
  logic                 w_xa;
  logic                 w_xb;
  logic                 w_inv;
  logic                 w_dz;
  logic                 w_mz;
  logic                 w_unp_spc;

  assign w_sa      = r_a[W-1];
  assign w_sb_raw  = r_b[W-1];
  assign w_sb_eff  = w_sb_raw ^ (r_op == OP_SUB);
  assign w_sxor    = w_sa ^ w_sb_raw;
  assign w_ea_f    = r_a[W-2:MAN_W];
  assign w_eb_f    = r_b[W-2:MAN_W];
  assign w_fa      = r_a[MAN_W-1:0];
  assign w_fb      = r_b[MAN_W-1:0];
  assign w_za      = (w_ea_f == '0);
  assign w_zb      = (w_eb_f == '0);
  assign w_xa      = (w_ea_f == EXP_ONES);
  assign w_xb      = (w_eb_f == EXP_ONES);
  assign w_inv     = w_xa || w_xb || ((r_op == OP_DIV) && w_za && w_zb);
  assign w_dz      = !w_inv && (r_op == OP_DIV) && w_zb;
  assign w_mz      = !w_inv && !w_dz && r_op[1] && (w_za || w_zb);
  assign w_unp_spc = w_inv || w_dz || w_mz;

  // Alignment shifter: the smaller-exponent mantissa moves right by the exponent gap.
  logic                 w_a_big;
  logic [EXP_W-1:0]     w_shamt;
  logic [SW-1:0]        w_small;
  logic [SW-1:0]        w_small_sh;

  assign w_a_big    = (r_ea >= r_eb);
  assign w_shamt    = w_a_big ? (r_ea - r_eb) : (r_eb - r_ea);
  assign w_small    = w_a_big ? r_mb : r_ma;
  assign w_small_sh = (32'(w_shamt) >= 32'(SW)) ? '0 : (w_small >> w_shamt);

  // Magnitude add/subtract of aligned mantissas.
  logic                 w_same;
  logic                 w_a_ge;
  logic [SW-1:0]        w_as_m;
  logic                 w_as_s;
  logic                 w_as_zero;

  assign w_same    = (r_sa == r_sb);
  assign w_a_ge    = (r_ma >= r_mb);
  assign w_as_m    = w_same ? (r_ma + r_mb) : (w_a_ge ? (r_ma - r_mb) : (r_mb - r_ma));
  assign w_as_s    = w_same ? r_sa : (w_a_ge ? r_sa : r_sb);
  assign w_as_zero = (w_as_m == '0);

  // One shift-add multiplier step; the top SW product bits are kept.
  logic [N:0]           w_mul_sum;
  logic [2*N-1:0]       w_prod_nx;
  logic [SW-1:0]        w_mul_keep;

  assign w_mul_sum  = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nx  = {w_mul_sum, r_prod[N-1:1]};
  assign w_mul_keep = w_prod_nx[2*N-1 -: SW];

  // One restoring-divider step; first quotient bit has weight 2, so 1.0 lands on the hidden bit.
  logic                 w_div_ge;
  logic [DW-1:0]        w_div_diff;
  logic [DW-1:0]        w_rem_nx;
  logic [SW-1:0]        w_q_nx;

  assign w_div_ge   = (r_rem >= r_dvs);
  assign w_div_diff = r_rem - r_dvs;
  assign w_rem_nx   = (w_div_ge ? w_div_diff : r_rem) << 1;
  assign w_q_nx     = {r_m[SW-2:0], w_div_ge};

  // Normalisation step: one right shift on carry, otherwise one left shift.
  logic [SW-1:0]        w_nm_nx;
  logic signed [XW-1:0] w_ne_nx;

  assign w_nm_nx = r_m[SW-1] ? (r_m >> 1) : (r_m << 1);
  assign w_ne_nx = r_m[SW-1] ? (r_exp + XW'(1)) : (r_exp - XW'(1));

  // Final packing with overflow/underflow saturation.
  logic [W-1:0]         w_pack_res;
  logic [3:0]           w_pack_flg;

  // Select the packed result and flags for the operation finishing in PACK.
  always_comb begin
    w_pack_res = {r_sign, r_exp[EXP_W-1:0], r_m[MAN_W-1:0]};
    w_pack_flg = 4'b0000;
    if (r_special) begin
      w_pack_res = r_pre;
      w_pack_flg = r_flg;
    end else if (r_exp >= EXP_MAX) begin
      w_pack_res = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_pack_flg = 4'b0010;
    end else if (r_exp <= EXP_ZERO) begin
      w_pack_res = {r_sign, {(W-1){1'b0}}};
      w_pack_flg = 4'b0001;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_UNPACK;
      S_UNPACK: begin
        if (w_unp_spc)          w_next = S_PACK;
        else if (!r_op[1])      w_next = S_ALIGN;
        else if (r_op == OP_MUL) w_next = S_MUL;
        else                    w_next = S_DIV;
      end
      S_ALIGN:  w_next = S_ADDSUB;
      S_ADDSUB: w_next = (w_as_zero || is_norm(w_as_m)) ? S_PACK : S_NORM;
      S_MUL:    if (r_cnt == '0) w_next = is_norm(w_mul_keep) ? S_PACK : S_NORM;
      S_DIV:    if (r_cnt == '0) w_next = is_norm(w_q_nx) ? S_PACK : S_NORM;
      S_NORM:   if (is_norm(w_nm_nx)) w_next = S_PACK;
      S_PACK:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_ea      <= '0;
      r_eb      <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_m       <= '0;
      r_special <= 1'b0;
      r_pre     <= '0;
      r_flg     <= '0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_UNPACK: begin
          r_special <= w_unp_spc;
          r_flg     <= {w_inv, w_dz, 2'b00};
          if (w_inv)     r_pre <= QNAN;
          else if (w_dz) r_pre <= {w_sxor, EXP_ONES, {MAN_W{1'b0}}};
          else           r_pre <= {w_sxor, {(W-1){1'b0}}};
          r_sa    <= w_sa;
          r_sb    <= w_sb_eff;
          r_ea    <= w_ea_f;
          r_eb    <= w_eb_f;
          r_ma    <= w_za ? '0 : {2'b01, w_fa};
          r_mb    <= w_zb ? '0 : {2'b01, w_fb};
          r_sign  <= w_sxor;
          if (r_op == OP_DIV) r_exp <= XW'(w_ea_f) - XW'(w_eb_f) + XW'(BIAS);
          else                r_exp <= XW'(w_ea_f) + XW'(w_eb_f) - XW'(BIAS);
          r_m     <= '0;
          r_mcand <= {1'b1, w_fa};
          r_prod  <= {{N{1'b0}}, 1'b1, w_fb};
          r_rem   <= DW'({1'b1, w_fa});
          r_dvs   <= DW'({1'b1, w_fb, 1'b0});
          r_cnt   <= (r_op == OP_MUL) ? CW'(N - 1) : CW'(SW - 1);
        end
        S_ALIGN: begin
          if (w_a_big) begin
            r_mb  <= w_small_sh;
            r_exp <= XW'(r_ea);
          end else begin
            r_ma  <= w_small_sh;
            r_exp <= XW'(r_eb);
          end
        end
        S_ADDSUB: begin
          r_m    <= w_as_m;
          r_sign <= w_as_s;
          if (w_as_zero) begin
            r_special <= 1'b1;
            r_pre     <= '0;
            r_flg     <= '0;
          end
        end
        S_MUL: begin
          r_prod <= w_prod_nx;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) r_m <= w_mul_keep;
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_m   <= w_q_nx;
          r_cnt <= r_cnt - CW'(1);
        end
        S_NORM: begin
          r_m   <= w_nm_nx;
          r_exp <= w_ne_nx;
        end
        default: ;
      endcase
    end
  end

  // Handshake and result registers; result/flags load on DONE entry and hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= (r_state == S_PACK);
      if (r_state == S_IDLE && start) r_busy <= 1'b1;
      else if (r_state == S_DONE)     r_busy <= 1'b0;
      if (r_state == S_PACK) begin
        r_result <= w_pack_res;
        r_flags  <= w_pack_flg;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_fpu_seq_core.sv
// Directed bench for fpu_seq_core at half precision (EXP_W=5, MAN_W=10).
module tb_fpu_seq_core;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  fpu_seq_core #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation; operands are scrambled after acceptance, and an extra start
  // is optionally pulsed in cycle 'poke' (start cycle counts as 1).
  task automatic run_op(input logic [1:0] o, input logic [15:0] xa, input logic [15:0] xb,
                        input int poke, output logic [15:0] res, output logic [3:0] flg,
                        output int lat, output logic bsy, output logic tail_ok, output logic tmo);
    @(negedge clk);
    op = o; a = xa; b = xb; start = 1'b1;
    lat = 1; tmo = 1'b1; bsy = 1'b0;
    for (int i = 0; i < 100 && tmo; i++) begin
      @(posedge clk); #1;
      lat++;
      a = ~xa; b = ~xb;
      if (done) begin
        tmo = 1'b0;
        start = 1'b0;
      end else begin
        start = (poke != 0) && (lat == poke);
        if (start) op = ADD;
      end
    end
    res = result; flg = flags; bsy = busy;
    @(posedge clk); #1;
    tail_ok = !done && !busy;
    start = 1'b0;
  endtask

  task automatic do_case(input string tag, input logic [1:0] o, input logic [15:0] xa,
                         input logic [15:0] xb, input int poke, input logic [15:0] eres,
                         input logic [3:0] eflg, input int elat);
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    logic        bsy, tail_ok, tmo;
    run_op(o, xa, xb, poke, res, flg, lat, bsy, tail_ok, tmo);
    chk({tag, "_timeout"}, 32'(tmo), 32'd0);
    chk({tag, "_result"}, 32'(res), 32'(eres));
    chk({tag, "_flags"}, 32'(flg), 32'(eflg));
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_at_done"}, 32'(bsy), 32'd1);
    chk({tag, "_done_pulse"}, 32'(tail_ok), 32'd1);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; op = ADD; a = '0; b = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    do_case("add_1p2",    ADD, 16'h3C00, 16'h4000, 0, 16'h4200, 4'b0000, 6);
    do_case("sub_cancel", SUB, 16'h3C00, 16'h3C00, 0, 16'h0000, 4'b0000, 6);
    do_case("sub_neg",    SUB, 16'h3800, 16'h3C00, 0, 16'hB800, 4'b0000, 7);
    do_case("add_carry",  ADD, 16'h3C00, 16'h3C00, 0, 16'h4000, 4'b0000, 7);
    do_case("add_shift10", ADD, 16'h6400, 16'h3C00, 0, 16'h6401, 4'b0000, 6);
    do_case("add_shift12", ADD, 16'h6C00, 16'h3C00, 0, 16'h6C00, 4'b0000, 6);
    do_case("mul_1p5x2",  MUL, 16'h3E00, 16'h4000, 0, 16'h4200, 4'b0000, 15);
    do_case("mul_neg",    MUL, 16'hBE00, 16'h4000, 0, 16'hC200, 4'b0000, 15);
    do_case("mul_ovf",    MUL, 16'h7BFF, 16'h4000, 0, 16'h7C00, 4'b0010, 15);
    do_case("mul_unf",    MUL, 16'h0400, 16'h0400, 0, 16'h0000, 4'b0001, 15);
    do_case("mul_zero",   MUL, 16'h8000, 16'h3C00, 0, 16'h8000, 4'b0000, 4);
    do_case("div_3by2",   DIV, 16'h4200, 16'h4000, 0, 16'h3E00, 4'b0000, 16);
    do_case("div_norm",   DIV, 16'h3C80, 16'h3E00, 0, 16'h3A00, 4'b0000, 17);
    do_case("div_by0",    DIV, 16'h3C00, 16'h0000, 0, 16'h7C00, 4'b0100, 4);
    do_case("add_inf",    ADD, 16'h7C00, 16'h3C00, 0, 16'h7E00, 4'b1000, 4);
    do_case("div_busy_start", DIV, 16'h4200, 16'h4000, 5, 16'h3E00, 4'b0000, 16);
    do_case("div_0by0",   DIV, 16'h0000, 16'h0000, 0, 16'h7E00, 4'b1000, 4);

    // Reset in the middle of a divide: outputs clear and no done follows.
    @(negedge clk);
    op = DIV; a = 16'h4200; b = 16'h4000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_div_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    @(negedge clk) rst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);

    do_case("recover_mul", MUL, 16'h3E00, 16'h4000, 0, 16'h4200, 4'b0000, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
